key_conditioner: RTL and testbench

Conditions one raw active-low push-button before it drives an FSM input such as `w`. It synchronizes the asynchronous key, debounces it, and produces three single-cycle event pulses: press, release and auto-repeat. It runs on the same divided clock as the downstream FSM. The top level instantiates one per KEY, except the reset key.

---
 rtl/key_conditioner.sv | 159 +++++++++++++++
 tb/tb_key_conditioner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: turns one raw active-low push-button into clean events.
// The asynchronous key passes through a two-flop synchronizer and a debounce
// counter. The result is a debounced level plus single-cycle press, release and
// auto-repeat pulses. It runs on the same clock as the FSM it feeds.
//
// Ports:
//   clk_i       block clock; all logic is on its rising edge
//   reset_i     synchronous, active-high reset
//   key_n_i     raw asynchronous button, 0 = pressed
//   pressed_o   debounced level, 1 = held
//   press_o     one-cycle pulse when pressed_o rises
//   release_o   one-cycle pulse when pressed_o falls
//   repeat_o    one-cycle auto-repeat pulse while held
module key_conditioner #(
   parameter int unsigned DEBOUNCE      = 4,
   parameter int unsigned REPEAT_DELAY  = 8,
   parameter int unsigned REPEAT_PERIOD = 3,
   parameter int unsigned CNT_W         = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic key_n_i,
   output logic pressed_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   // A zero delay disables auto-repeat; the FSM still parks in REPEAT.
   localparam bit REP_EN = (REPEAT_DELAY != 0);

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST =
      REP_EN ? CNT_W'(REPEAT_DELAY - 1) : '0;
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic             pressed_q, pressed_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic             repeat_q, repeat_d;

   logic             raw_c;
   logic             settle_c;
   logic             rise_c;
   logic             fall_c;

   // Synchronizer, debounce and edge detection.
   always_comb begin
      s1_d      = key_n_i;
      s2_d      = s1_q;
      dcnt_d    = dcnt_q;
      pressed_d = pressed_q;

      raw_c    = ~s2_q;
      settle_c = (raw_c != pressed_q) && (dcnt_q == DEB_LAST);
      rise_c   = settle_c && raw_c;
      fall_c   = settle_c && !raw_c;

      // Any agreeing cycle restarts the count, so short glitches are ignored.
      if (raw_c == pressed_q) begin
         dcnt_d = '0;
      end else if (settle_c) begin
         pressed_d = raw_c;
         dcnt_d    = '0;
      end else begin
         dcnt_d = dcnt_q + CNT_W'(1);
      end

      press_d   = rise_c;
      release_d = fall_c;
   end

   // Auto-repeat FSM: next state, counter and pulse.
   always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      repeat_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rise_c) begin
               rcnt_d  = '0;
               state_d = REP_EN ? ST_DELAY : ST_REPEAT;
            end
         end
         ST_DELAY: begin
            if (rcnt_q == DELAY_LAST) begin
               repeat_d = 1'b1;
               rcnt_d   = '0;
               state_d  = ST_REPEAT;
            end else begin
               rcnt_d = rcnt_q + CNT_W'(1);
            end
         end
         ST_REPEAT: begin
            // Only reachable without a delay when repeat is disabled; stay quiet.
            if (REP_EN) begin
               if (rcnt_q == PERIOD_LAST) begin
                  repeat_d = 1'b1;
                  rcnt_d   = '0;
               end else begin
                  rcnt_d = rcnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
         end
      endcase

      // Release overrides everything, including a coincident repeat.
      if (fall_c) begin
         state_d  = ST_IDLE;
         rcnt_d   = '0;
         repeat_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_q      <= 1'b1;
         s2_q      <= 1'b1;
         dcnt_q    <= '0;
         pressed_q <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         state_q   <= ST_IDLE;
         rcnt_q    <= '0;
         repeat_q  <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         dcnt_q    <= dcnt_d;
         pressed_q <= pressed_d;
         press_q   <= press_d;
         release_q <= release_d;
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         repeat_q  <= repeat_d;
      end
   end

   assign pressed_o = pressed_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: two instances (auto-repeat on / off) share one
// stimulus; a cycle-level behavioural model is checked every cycle, and
// hand-derived edge numbers pin the model down for each directed scenario.
module tb_key_conditioner;

   localparam int DEB = 4;
   localparam int RD  = 8;
   localparam int RP  = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic key_n = 1'b1;

   logic a_pressed, a_press, a_release, a_repeat;
   logic b_pressed, b_press, b_release, b_repeat;

   key_conditioner #(.DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(16)) u_rep (
      .clk_i(clk), .reset_i(reset), .key_n_i(key_n),
      .pressed_o(a_pressed), .press_o(a_press), .release_o(a_release), .repeat_o(a_repeat));

   key_conditioner #(.DEBOUNCE(DEB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP), .CNT_W(16)) u_norep (
      .clk_i(clk), .reset_i(reset), .key_n_i(key_n),
      .pressed_o(b_pressed), .press_o(b_press), .release_o(b_release), .repeat_o(b_repeat));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // run: consecutive cycles the (delayed) key level disagreed with pressed.
   // age: cycles since the press pulse; repeats fall at age = rd + n*RP.
   typedef struct {
      bit pressed; bit press; bit rel; bit rep;
      int run; int age;
   } mstate_t;

   function automatic mstate_t m_reset();
      mstate_t s;
      s.pressed = 0; s.press = 0; s.rel = 0; s.rep = 0; s.run = 0; s.age = 0;
      return s;
   endfunction

   function automatic mstate_t m_step(mstate_t s, bit raw, int rd);
      mstate_t n = s;
      n.press = 0; n.rel = 0; n.rep = 0;
      if (raw != s.pressed) begin
         n.run = s.run + 1;
         if (n.run == DEB) begin
            n.pressed = raw; n.run = 0;
            n.press = raw; n.rel = !raw; n.age = 0;
         end
      end else begin
         n.run = 0;
      end
      if (n.pressed && !n.press) begin
         n.age = s.age + 1;
         n.rep = (rd > 0) && (n.age >= rd) && (((n.age - rd) % RP) == 0);
      end
      return n;
   endfunction

   // Key level as the block sees it is the sample taken two edges earlier.
   bit k1 = 1, k2 = 1;
   mstate_t ma = m_reset();
   mstate_t mb = m_reset();

   always @(posedge clk) begin
      if (reset) begin
         k1 <= 1; k2 <= 1;
         ma <= m_reset(); mb <= m_reset();
      end else begin
         ma <= m_step(ma, !k2, RD);
         mb <= m_step(mb, !k2, 0);
         k2 <= k1;
         k1 <= key_n;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 0;
   bit pa_press = 0, pa_rel = 0, pa_rep = 0, pb_press = 0, pb_rel = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rep.pressed", a_pressed, ma.pressed);
         chk("rep.press",   a_press,   ma.press);
         chk("rep.release", a_release, ma.rel);
         chk("rep.repeat",  a_repeat,  ma.rep);
         chk("norep.pressed", b_pressed, mb.pressed);
         chk("norep.press",   b_press,   mb.press);
         chk("norep.release", b_release, mb.rel);
         chk("norep.repeat",  b_repeat,  mb.rep);
         chk("rep.press_and_release", a_press & a_release, 0);
         chk("norep.press_and_release", b_press & b_release, 0);
         chk("rep.press_consecutive", pa_press & a_press, 0);
         chk("rep.release_consecutive", pa_rel & a_release, 0);
         chk("rep.repeat_consecutive", pa_rep & a_repeat, 0);
         chk("norep.press_consecutive", pb_press & b_press, 0);
         chk("norep.release_consecutive", pb_rel & b_release, 0);
      end
      pa_press = a_press; pa_rel = a_release; pa_rep = a_repeat;
      pb_press = b_press; pb_rel = b_release;
   end

   // ---------------- directed stimulus with recorded events ----------------
   int se;
   int a_press_first, a_press_late, a_rel_first, a_rep_cnt, a_rep_first, a_rep_last;
   int b_press_first, b_rel_first, b_rep_cnt;
   int any_hi, pressed_hi, rel_early, out_at15;

   task automatic clear_rec();
      se = 0;
      a_press_first = -1; a_press_late = -1; a_rel_first = -1;
      a_rep_cnt = 0; a_rep_first = -1; a_rep_last = -1;
      b_press_first = -1; b_rel_first = -1; b_rep_cnt = 0;
      any_hi = 0; pressed_hi = 0; rel_early = 0; out_at15 = -1;
   endtask

   // Apply one input vector, clock one edge, and record what the DUTs show.
   task automatic cyc(input bit k, input bit r);
      key_n = k;
      reset = r;
      @(posedge clk);
      #2;
      if (a_press && a_press_first < 0) a_press_first = se;
      if (a_press && se > 15 && a_press_late < 0) a_press_late = se;
      if (a_release && a_rel_first < 0) a_rel_first = se;
      if (a_release && se <= 21) rel_early++;
      if (a_repeat) begin
         a_rep_cnt++;
         if (a_rep_first < 0) a_rep_first = se;
         a_rep_last = se;
      end
      if (b_press && b_press_first < 0) b_press_first = se;
      if (b_release && b_rel_first < 0) b_rel_first = se;
      if (b_repeat) b_rep_cnt++;
      if (a_pressed | a_press | a_release | a_repeat |
          b_pressed | b_press | b_release | b_repeat) any_hi++;
      if (a_pressed | b_pressed) pressed_hi++;
      if (se == 15) out_at15 = a_pressed + a_press + a_release + a_repeat
                               + b_pressed + b_press + b_release + b_repeat;
      se++;
   endtask

   bit pat [7] = '{0, 0, 1, 0, 0, 0, 1};

   initial begin
      clear_rec();
      cyc(1, 1);
      cyc(1, 1);
      chk_en = 1;
      chk("reset.pressed", a_pressed, 0);
      chk("reset.pulses", a_press | a_release | a_repeat, 0);

      // Idle key: nothing ever asserts.
      clear_rec();
      for (int i = 0; i < 20; i++) cyc(1, 0);
      chk("idle.any_output", any_hi, 0);

      // Long hold: press after edge 5, repeats 13..34, release after edge 35.
      clear_rec();
      for (int i = 0; i < 30; i++) cyc(0, 0);
      for (int i = 0; i < 15; i++) cyc(1, 0);
      chk("hold.press_edge", a_press_first, 5);
      chk("hold.release_edge", a_rel_first, 35);
      chk("hold.repeat_count", a_rep_cnt, 8);
      chk("hold.repeat_first", a_rep_first, 13);
      chk("hold.repeat_last", a_rep_last, 34);
      chk("norep.press_edge", b_press_first, 5);
      chk("norep.release_edge", b_rel_first, 35);
      chk("norep.repeat_count", b_rep_cnt, 0);

      // Bounce shorter than the debounce window never registers.
      clear_rec();
      for (int i = 0; i < 7; i++) cyc(pat[i], 0);
      for (int i = 0; i < 15; i++) cyc(1, 0);
      chk("bounce.pressed_cycles", pressed_hi, 0);
      chk("bounce.any_output", any_hi, 0);

      // Reset pulsed mid-hold: silent clear, press comes back after edge 21.
      clear_rec();
      for (int i = 0; i < 30; i++) cyc(0, (i == 15));
      for (int i = 0; i < 15; i++) cyc(1, 0);
      chk("rst_mid.press_edge", a_press_first, 5);
      chk("rst_mid.outputs_at_15", out_at15, 0);
      chk("rst_mid.no_release", rel_early, 0);
      chk("rst_mid.press_again", a_press_late, 21);
      chk("rst_mid.release_edge", a_rel_first, 35);

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
